trace_buffer: RTL and testbench

Synthesizable instruction-trace capture buffer for the single-cycle RV32I core. It records one entry per retired instruction (PC, instruction, ALU result, load data, sequence number) into a parametrised circular store. It supports trigger-on-PC arming, wrap or freeze-when-full modes and a ready/valid drain port. It sits beside the core datapath and replaces simulation-only register/PC logging with hardware capture that can be drained by a debug port or a testbench.

---
 rtl/trace_buffer.sv | 176 +++++++++++++++++
 tb/tb_trace_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_buffer
//  Description : Instruction-trace capture buffer for the single-cycle RV32I
//                core. Records PC, instruction, ALU result, load data and a
//                sequence number per retired instruction into a circular
//                store. Supports PC-triggered arming, wrap or freeze-when-full
//                operation and a ready/valid drain port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_rst        clock, synchronous active-high reset
//    i_clear             synchronous soft clear (i_rst has priority)
//    i_en                capture enable
//    i_trig_en/i_trig_pc wait for a PC match before capturing
//    i_wrap              1: overwrite oldest when full, 0: freeze when full
//    i_valid, i_pc, i_instr, i_alu_data, i_ld_data   retired instruction
//    i_rd_ready          consumer accepts head entry
//    o_rd_valid, o_rd_pc, o_rd_instr, o_rd_alu, o_rd_ld, o_rd_seq  head entry
//    o_count, o_full, o_empty   occupancy
//    o_overflow, o_drop_cnt     loss reporting (sticky / saturating)
//    o_state                    IDLE=0 ARMED=1 CAPTURE=2 FROZEN=3
// ============================================================================
module trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int XLEN        = 32,
  parameter int SEQ_W       = 16,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_en,
  input  logic                       i_trig_en,
  input  logic [XLEN-1:0]            i_trig_pc,
  input  logic                       i_wrap,
  input  logic                       i_valid,
  input  logic [XLEN-1:0]            i_pc,
  input  logic [XLEN-1:0]            i_instr,
  input  logic [XLEN-1:0]            i_alu_data,
  input  logic [XLEN-1:0]            i_ld_data,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [XLEN-1:0]            o_rd_pc,
  output logic [XLEN-1:0]            o_rd_instr,
  output logic [XLEN-1:0]            o_rd_alu,
  output logic [XLEN-1:0]            o_rd_ld,
  output logic [SEQ_W-1:0]           o_rd_seq,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_cnt,
  output logic [1:0]                 o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_mem_pc    [DEPTH];
  logic [XLEN-1:0]   r_mem_instr [DEPTH];
  logic [XLEN-1:0]   r_mem_alu   [DEPTH];
  logic [XLEN-1:0]   r_mem_ld    [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq   [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [SEQ_W-1:0]  r_seq;
  logic [XLEN-1:0]   r_last_pc;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic w_ev, w_full, w_empty, w_pop;
  logic w_push_req, w_frozen_ev, w_write, w_drop, w_rd_adv, w_seq_inc;

  assign w_ev    = i_valid && ((CHANGE_ONLY == 0) || (i_pc != r_last_pc));
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && i_rd_ready;

  // Next-state and push qualification
  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_frozen_ev = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = i_trig_en ? ST_ARMED : ST_CAPTURE;
      end
      ST_ARMED: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ev && (i_pc == i_trig_pc)) begin
          // The triggering sample itself is captured
          w_push_req  = 1'b1;
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!i_en) w_state_nxt = ST_IDLE;
        else       w_push_req  = w_ev;
      end
      ST_FROZEN: begin
        w_frozen_ev = w_ev;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A push that would be lost in freeze mode parks the buffer
    if (w_push_req && w_full && !w_pop && !i_wrap) w_state_nxt = ST_FROZEN;
  end

  assign w_write   = w_push_req && (!w_full || w_pop || i_wrap);
  // Full with no pop: in wrap mode the oldest entry is overwritten, so the
  // read pointer advances along with the write pointer.
  assign w_rd_adv  = w_pop || (w_push_req && w_full && !w_pop && i_wrap);
  assign w_drop    = (w_push_req && w_full && !w_pop) || w_frozen_ev;
  assign w_seq_inc = w_push_req || w_frozen_ev;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_last_pc  <= '1;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ev)      r_last_pc <= i_pc;
      if (w_seq_inc) r_seq     <= r_seq + SEQ_W'(1);
      if (w_write)   r_wr_ptr  <= r_wr_ptr + AW'(1);
      if (w_rd_adv)  r_rd_ptr  <= r_rd_ptr + AW'(1);
      if (w_write && !w_rd_adv)      r_count <= r_count + CW'(1);
      else if (!w_write && w_rd_adv) r_count <= r_count - CW'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Storage is never reset so it can map onto RAM
  always_ff @(posedge i_clk) begin
    if (w_write && !i_rst && !i_clear) begin
      r_mem_pc[r_wr_ptr]    <= i_pc;
      r_mem_instr[r_wr_ptr] <= i_instr;
      r_mem_alu[r_wr_ptr]   <= i_alu_data;
      r_mem_ld[r_wr_ptr]    <= i_ld_data;
      r_mem_seq[r_wr_ptr]   <= r_seq;
    end
  end

  assign o_rd_valid = !w_empty;
  assign o_rd_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign o_rd_instr = w_empty ? '0 : r_mem_instr[r_rd_ptr];
  assign o_rd_alu   = w_empty ? '0 : r_mem_alu[r_rd_ptr];
  assign o_rd_ld    = w_empty ? '0 : r_mem_ld[r_rd_ptr];
  assign o_rd_seq   = w_empty ? '0 : r_mem_seq[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
  assign o_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trace_buffer
//  Description : Self-checking bench for trace_buffer (DEPTH=4). A scoreboard
//                queue holds the entries expected in the buffer; entries are
//                pushed when a capturing sample is driven and popped/compared
//                when the consumer takes the head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int SEQ_W = 16;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] seq;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, clear, en, trig_en, wrap, valid, rd_ready;
  logic [31:0] trig_pc, pc, instr, alu, ld;
  logic        rd_valid, full, empty, overflow;
  logic [31:0] rd_pc, rd_instr, rd_alu, rd_ld;
  logic [15:0] rd_seq, drop_cnt;
  logic [2:0]  count;
  logic [1:0]  state;

  entry_t      sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_seq;
  logic [15:0] exp_drop;

  always #5 clk = ~clk;

  trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .SEQ_W(SEQ_W), .CHANGE_ONLY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_en(en),
    .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_wrap(wrap),
    .i_valid(valid), .i_pc(pc), .i_instr(instr), .i_alu_data(alu), .i_ld_data(ld),
    .i_rd_ready(rd_ready),
    .o_rd_valid(rd_valid), .o_rd_pc(rd_pc), .o_rd_instr(rd_instr),
    .o_rd_alu(rd_alu), .o_rd_ld(rd_ld), .o_rd_seq(rd_seq),
    .o_count(count), .o_full(full), .o_empty(empty),
    .o_overflow(overflow), .o_drop_cnt(drop_cnt), .o_state(state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then observed 1 ns after it
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Payload fields are derived from the PC so the bench can predict them
  function automatic logic [31:0] f_instr(input logic [31:0] p); return p ^ 32'hA5A5_0000; endfunction
  function automatic logic [31:0] f_alu(input logic [31:0] p);   return p + 32'h1000;      endfunction
  function automatic logic [31:0] f_ld(input logic [31:0] p);    return ~p;                endfunction

  // One cycle of traffic. mode: 0 = no capture expected, 1 = capturing ev,
  // 2 = ev while frozen (lost).
  task automatic step(input logic v, input logic [31:0] p, input int mode);
    entry_t e;
    bit     popped;
    check("rd_valid", {63'd0, rd_valid}, {63'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("head_pc",    {32'd0, rd_pc},    {32'd0, sb[0].pc});
      check("head_seq",   {48'd0, rd_seq},   {48'd0, sb[0].seq});
      check("head_instr", {32'd0, rd_instr}, {32'd0, f_instr(sb[0].pc)});
      check("head_alu",   {32'd0, rd_alu},   {32'd0, f_alu(sb[0].pc)});
      check("head_ld",    {32'd0, rd_ld},    {32'd0, f_ld(sb[0].pc)});
    end else begin
      check("empty_pc", {32'd0, rd_pc}, 64'd0);
    end
    popped = rd_ready && (sb.size() != 0);
    valid = v; pc = p; instr = f_instr(p); alu = f_alu(p); ld = f_ld(p);
    cycle();
    valid = 1'b0;
    if (popped) void'(sb.pop_front());
    if (mode == 1) begin
      e.pc = p; e.seq = exp_seq;
      if (sb.size() < DEPTH) sb.push_back(e);
      else if (wrap) begin void'(sb.pop_front()); sb.push_back(e); exp_drop++; end
      else exp_drop++;
      exp_seq++;
    end else if (mode == 2) begin
      exp_drop++;
      exp_seq++;
    end
    check("count", {61'd0, count}, 64'(sb.size()));
    check("drop_cnt", {48'd0, drop_cnt}, {48'd0, exp_drop});
  endtask

  task automatic do_clear();
    clear = 1'b1; en = 1'b0;
    cycle();
    clear = 1'b0;
    sb.delete(); exp_seq = '0; exp_drop = '0;
    check("clr_state", {62'd0, state}, 64'd0);
    check("clr_count", {61'd0, count}, 64'd0);
    check("clr_ovf",   {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; en = 1'b0; trig_en = 1'b0; trig_pc = '0;
    wrap = 1'b0; valid = 1'b0; pc = '0; instr = '0; alu = '0; ld = '0;
    rd_ready = 1'b0; exp_seq = '0; exp_drop = '0;
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full",  {63'd0, full}, 64'd0);
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_ovf",   {63'd0, overflow}, 64'd0);
    check("rst_drop",  {48'd0, drop_cnt}, 64'd0);
    check("rst_rd_pc", {32'd0, rd_pc}, 64'd0);

    // 1: direct capture, repeated PC skipped; ev in the enabling cycle is lost
    en = 1'b1;
    step(1'b1, 32'h100, 0);
    check("t1_state", {62'd0, state}, 64'd2);
    step(1'b1, 32'h0, 1);
    step(1'b1, 32'h4, 1);
    step(1'b1, 32'h4, 0);
    step(1'b1, 32'h8, 1);
    step(1'b0, 32'h0, 0);
    check("t1_count3", {61'd0, count}, 64'd3);
    rd_ready = 1'b1;
    repeat (4) step(1'b0, 32'h0, 0);
    rd_ready = 1'b0;
    check("t1_empty", {63'd0, empty}, 64'd1);

    // 2: PC trigger
    do_clear();
    en = 1'b1; trig_en = 1'b1; trig_pc = 32'h10;
    cycle();
    check("t2_armed", {62'd0, state}, 64'd1);
    step(1'b1, 32'h0, 0);
    step(1'b1, 32'h4, 0);
    check("t2_still_armed", {62'd0, state}, 64'd1);
    step(1'b1, 32'h10, 1);
    check("t2_capture", {62'd0, state}, 64'd2);
    step(1'b1, 32'h14, 1);
    rd_ready = 1'b1;
    repeat (3) step(1'b0, 32'h0, 0);
    rd_ready = 1'b0;
    trig_en = 1'b0;

    // 3: wrap mode, 6 captures into 4 entries
    do_clear();
    wrap = 1'b1; en = 1'b1;
    cycle();
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), 1);
    check("t3_full", {63'd0, full}, 64'd1);
    check("t3_ovf",  {63'd0, overflow}, 64'd1);
    check("t3_drop", {48'd0, drop_cnt}, 64'd2);
    check("t3_head", {32'd0, rd_pc}, 64'h8);
    rd_ready = 1'b1;
    repeat (5) step(1'b0, 32'h0, 0);
    rd_ready = 1'b0;

    // 4: freeze mode
    do_clear();
    wrap = 1'b0; en = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 1);
    check("t4_frozen", {62'd0, state}, 64'd3);
    step(1'b1, 32'h14, 2);
    check("t4_drop", {48'd0, drop_cnt}, 64'd2);
    check("t4_head", {32'd0, rd_pc}, 64'h0);
    rd_ready = 1'b1;
    repeat (5) step(1'b0, 32'h0, 0);
    rd_ready = 1'b0;
    check("t4_stay_frozen", {62'd0, state}, 64'd3);

    // 5: full with continuous simultaneous push and pop
    do_clear();
    en = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(i * 4), 1);
    check("t5_full", {63'd0, full}, 64'd1);
    rd_ready = 1'b1;
    for (int i = 4; i < 10; i++) begin
      step(1'b1, 32'h200 + 32'(i * 4), 1);
      check("t5_count4", {61'd0, count}, 64'd4);
    end
    check("t5_nodrop", {48'd0, drop_cnt}, 64'd0);
    repeat (5) step(1'b0, 32'h0, 0);
    rd_ready = 1'b0;

    // 6: reset mid-capture with a concurrent push and pop
    do_clear();
    en = 1'b1;
    cycle();
    step(1'b1, 32'h300, 1);
    step(1'b1, 32'h304, 1);
    check("t6_count2", {61'd0, count}, 64'd2);
    rst = 1'b1; rd_ready = 1'b1; valid = 1'b1; pc = 32'h308;
    cycle();
    rst = 1'b0; rd_ready = 1'b0; valid = 1'b0;
    sb.delete(); exp_seq = '0; exp_drop = '0;
    check("t6_count0", {61'd0, count}, 64'd0);
    check("t6_valid0", {63'd0, rd_valid}, 64'd0);
    check("t6_idle",   {62'd0, state}, 64'd0);
    cycle();
    check("t6_recap", {62'd0, state}, 64'd2);
    step(1'b1, 32'h40, 1);
    check("t6_seq0", {48'd0, rd_seq}, 64'd0);
    rd_ready = 1'b1;
    repeat (2) step(1'b0, 32'h0, 0);
    rd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
